bp_event_counter_bank: RTL
==========================

Name: bp_event_counter_bank

Overview:
- Parametrised successor to the fixed-function commit/stall profiler counter set.
- Provides channels_p independent event counters, each width_p bits, with selectable saturate or wrap overflow policy and sticky per-channel overflow flags.
- Accepts a per-channel event bitmask plus one encoded "category" event per cycle (the stall-reason path).
- Captures all counters into a snapshot bank on demand or on a programmable periodic interval, so host software reads a coherent set of values.
- Sits between the core profiling taps and the shell CSR readout.

Parameters:
channels_p, 64, number of counter channels
width_p, 32, counter and snapshot width in bits
saturate_p, 1, 1 = counters saturate at 2^width_p-1; 0 = counters wrap to 0
seq_width_p, 16, snapshot sequence-number width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous reset, active-low
en_i  in  1  global count enable; gates all increments and the interval timer
clear_i  in  1  zero live counters, overflow flags and interval timer
up_i  in  channels_p  per-channel increment request
cat_v_i  in  1  category event valid
cat_i  in  clog2(channels_p)  category channel index
interval_i  in  width_p  periodic snapshot interval in cycles; 0 = periodic snapshots disabled
snap_i  in  1  on-demand snapshot request
count_o  out  channels_p x width_p  live counter values
overflow_o  out  channels_p  sticky overflow flags
snap_o  out  channels_p x width_p  snapshot bank
snap_overflow_o  out  channels_p  overflow flags captured with the snapshot
snap_v_o  out  1  one-cycle pulse, snapshot bank updated
snap_seq_o  out  seq_width_p  snapshot sequence number

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - All counters, flags, snapshots, timer, snap_seq_o and snap_v_o go to 0.
  - Reset mid-interval discards partial timer progress.
- Increment condition: inc[c] = en_i & (up_i[c] | (cat_v_i & cat_i==c)).
  - Each channel increments by at most 1 per cycle; up_i and cat on the same channel still give +1.
  - cat_i >= channels_p is ignored.
- Overflow: when inc[c] and count[c] == 2^width_p-1:
  - saturate_p=1: count holds at max.
  - saturate_p=0: count becomes 0.
  - Either way overflow_o[c] sets and stays set until clear_i or reset.
- Counter latency: count_o reflects an increment one cycle after inc.
- clear_i:
  - Takes priority over increments in the same cycle; counters, flags and timer are 0 next cycle.
  - Does not alter snap_o, snap_overflow_o or snap_seq_o.
- Interval timer:
  - When interval_i != 0 and en_i, the timer counts cycles.
  - When timer == interval_i-1, a periodic trigger fires and the timer returns to 0.
  - If interval_i changes to a value <= the current timer, the trigger fires on the next enabled cycle and the timer restarts.
  - interval_i=0 holds the timer at 0.
- Snapshot trigger = snap_i | periodic trigger. Simultaneous sources yield exactly one snapshot.
  - snap_i is honoured even when en_i=0.
- Snapshot capture:
  - On trigger in cycle T, snap_o/snap_overflow_o load the register values visible in cycle T, before cycle T's increment or clear.
  - snap_v_o pulses in cycle T+1; snap_seq_o increments in T+1 and wraps modulo 2^seq_width_p.
  - A trigger coincident with clear_i captures the pre-clear values.
- Back-to-back triggers in consecutive cycles produce consecutive snapshots; snap_v_o then stays high for each.
- en_i=0 freezes counters and timer; clear_i and snap_i still act.

Test Plan:
- Reset with up_i all-ones, then release with en_i=1, up_i[3]=1 for 10 cycles -> count_o[3]=10, all other channels 0, overflow_o=0.
- up_i[5]=1 and cat_v_i=1, cat_i=5 for 4 cycles; cat_i=7 alone for 2 cycles -> count_o[5]=4, count_o[7]=2.
- saturate_p=1, width_p=4: 20 increments on ch0 -> count_o[0]=15, overflow_o[0]=1. Same with saturate_p=0 -> count_o[0]=4, overflow_o[0]=1.
- interval_i=8, en_i=1 continuously, up_i[0]=1 -> snap_v_o pulses every 8 cycles; successive snap_o[0] values differ by 8; snap_seq_o=1,2,3.
- snap_i and clear_i asserted together with count_o[2]=37 -> snap_o[2]=37, count_o[2]=0 next cycle, snap_seq_o increments by exactly 1.
- Reset asserted mid-interval (timer at 5 of 8), then released -> all outputs 0; first periodic snap_v_o occurs 8 enabled cycles after release.

Source files
------------

// File: rtl/bp_event_counter_bank.sv
// Bank of per-channel event counters with sticky overflow flags, a category
// event input, and a snapshot bank loaded on request or on a periodic interval.
module bp_event_counter_bank #(
  parameter int channels_p  = 64,
  parameter int width_p     = 32,
  parameter int saturate_p  = 1,
  parameter int seq_width_p = 16,
  localparam int cat_w_lp   = (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          en_i,
  input  logic                          clear_i,
  input  logic [channels_p-1:0]         up_i,
  input  logic                          cat_v_i,
  input  logic [cat_w_lp-1:0]           cat_i,
  input  logic [width_p-1:0]            interval_i,
  input  logic                          snap_i,
  output logic [channels_p*width_p-1:0] count_o,
  output logic [channels_p-1:0]         overflow_o,
  output logic [channels_p*width_p-1:0] snap_o,
  output logic [channels_p-1:0]         snap_overflow_o,
  output logic                          snap_v_o,
  output logic [seq_width_p-1:0]        snap_seq_o
);

  localparam logic [width_p-1:0] max_lp = {width_p{1'b1}};

  logic [width_p-1:0]     timer_q, timer_d;
  logic                   periodic_fire;
  logic                   trigger;
  logic                   snap_v_q;
  logic [seq_width_p-1:0] seq_q, seq_d;

  // Using >= rather than == also covers an interval shrunk below the running timer.
  assign periodic_fire = en_i && (interval_i != '0) &&
                         (timer_q >= (interval_i - width_p'(1)));
  assign trigger = snap_i | periodic_fire;

  always_comb begin
    timer_d = timer_q;
    if (clear_i || (interval_i == '0)) begin
      timer_d = '0;
    end else if (en_i) begin
      timer_d = periodic_fire ? '0 : timer_q + width_p'(1);
    end
  end

  assign seq_d = trigger ? seq_q + seq_width_p'(1) : seq_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      timer_q  <= '0;
      snap_v_q <= 1'b0;
      seq_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      snap_v_q <= trigger;
      seq_q    <= seq_d;
    end
  end

  assign snap_v_o   = snap_v_q;
  assign snap_seq_o = seq_q;

  for (genvar gi = 0; gi < channels_p; gi++) begin : g_ch
    logic               inc;
    logic [width_p-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [width_p-1:0] snap_q;
    logic               snap_ovf_q;

    // Out-of-range category indices never match any channel.
    assign inc = en_i & (up_i[gi] | (cat_v_i & (cat_i == cat_w_lp'(gi))));

    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear_i) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (inc) begin
        if (cnt_q == max_lp) begin
          cnt_d = (saturate_p != 0) ? max_lp : '0;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + width_p'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
        snap_q     <= '0;
        snap_ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        if (trigger) begin
          snap_q     <= cnt_q;
          snap_ovf_q <= ovf_q;
        end
      end
    end

    assign count_o[gi*width_p +: width_p] = cnt_q;
    assign overflow_o[gi]                 = ovf_q;
    assign snap_o[gi*width_p +: width_p]  = snap_q;
    assign snap_overflow_o[gi]            = snap_ovf_q;
  end

endmodule
